// File: rtl/db_req_arbiter.sv
// db_req_arbiter: two-port round-robin front end for db_top with an in-order tag FIFO.
// Define DB_ARB_STATS_EN to add per-port accept counters and an orphan drop counter.
module db_req_arbiter #(
  parameter int KEY_SIZE  = 96,
  parameter int FLAG_SIZE = 4,
  parameter int TAG_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [KEY_SIZE-1:0]          p0_key,
  input  logic [FLAG_SIZE-1:0]         p0_flag,
  input  logic                         p0_valid,
  output logic                         p0_ready,
  input  logic [KEY_SIZE-1:0]          p1_key,
  input  logic [FLAG_SIZE-1:0]         p1_flag,
  input  logic                         p1_valid,
  output logic                         p1_ready,
  output logic                         p0_out_valid,
  output logic [FLAG_SIZE-1:0]         p0_out_flag,
  output logic                         p1_out_valid,
  output logic [FLAG_SIZE-1:0]         p1_out_flag,
  output logic [KEY_SIZE-1:0]          db_key,
  output logic [FLAG_SIZE-1:0]         db_flag,
  output logic                         db_valid,
  input  logic                         db_out_valid,
  input  logic [FLAG_SIZE-1:0]         db_out_flag,
  output logic [$clog2(TAG_DEPTH):0]   outstanding,
`ifdef DB_ARB_STATS_EN
  output logic [31:0]                  p0_req_cnt,
  output logic [31:0]                  p1_req_cnt,
  output logic [15:0]                  drop_cnt,
`endif
  output logic                         err_orphan
);

  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(TAG_DEPTH);

  logic          last_grant;
  logic          grant;
  logic          not_full;
  logic          win_valid;
  logic          accept;
  logic          pop;
  logic          orphan;
  logic          head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          tags [TAG_DEPTH];

  always_comb begin
    grant = 1'b0;
    unique case (1'b1)
      p0_valid && p1_valid:  grant = ~last_grant;
      p1_valid && !p0_valid: grant = 1'b1;
      default:               grant = 1'b0;
    endcase
  end

  // ready uses the registered count, so a same-cycle pop cannot free a slot
  assign not_full  = outstanding < FULL;
  assign p0_ready  = !grant && not_full;
  assign p1_ready  = grant && not_full;
  assign win_valid = grant ? p1_valid : p0_valid;
  assign accept    = win_valid && not_full;
  assign pop       = db_out_valid && (outstanding != '0);
  assign orphan    = db_out_valid && (outstanding == '0);
  assign head      = tags[rd_ptr];

  always_ff @(posedge clk) begin
    if (accept) tags[wr_ptr] <= grant;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant   <= 1'b1;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      outstanding  <= '0;
      db_valid     <= 1'b0;
      db_key       <= '0;
      db_flag      <= '0;
      p0_out_valid <= 1'b0;
      p1_out_valid <= 1'b0;
      p0_out_flag  <= '0;
      p1_out_flag  <= '0;
      err_orphan   <= 1'b0;
    end else begin
      db_valid     <= accept;
      p0_out_valid <= pop && !head;
      p1_out_valid <= pop && head;
      if (accept) begin
        db_key     <= grant ? p1_key : p0_key;
        db_flag    <= grant ? p1_flag : p0_flag;
        wr_ptr     <= wr_ptr + PW'(1);
        last_grant <= grant;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        if (head) p1_out_flag <= db_out_flag;
        else      p0_out_flag <= db_out_flag;
      end
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
      if (orphan) err_orphan <= 1'b1;
    end
  end

`ifdef DB_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      p0_req_cnt <= '0;
      p1_req_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      if (accept && !grant) p0_req_cnt <= p0_req_cnt + 32'd1;
      if (accept && grant)  p1_req_cnt <= p1_req_cnt + 32'd1;
      if (orphan && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_db_req_arbiter.sv
// tb_db_req_arbiter: randomized scoreboard bench for db_req_arbiter.
// A queue-based reference model predicts grants, routing and occupancy.
module tb_db_req_arbiter;
  localparam int KW = 96;
  localparam int FW = 4;
  localparam int D  = 4;
  localparam int OW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [KW-1:0] p0_key, p1_key, db_key;
  logic [FW-1:0] p0_flag, p1_flag, db_flag;
  logic          p0_valid, p1_valid, p0_ready, p1_ready;
  logic          p0_out_valid, p1_out_valid;
  logic [FW-1:0] p0_out_flag, p1_out_flag;
  logic          db_valid, db_out_valid;
  logic [FW-1:0] db_out_flag;
  logic [OW-1:0] outstanding;
  logic          err_orphan;
`ifdef DB_ARB_STATS_EN
  logic [31:0]   p0_req_cnt, p1_req_cnt;
  logic [15:0]   drop_cnt;
`endif

  always #5 clk = ~clk;

  db_req_arbiter #(.KEY_SIZE(KW), .FLAG_SIZE(FW), .TAG_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .p0_key(p0_key), .p0_flag(p0_flag),
    .p0_valid(p0_valid), .p0_ready(p0_ready),
    .p1_key(p1_key), .p1_flag(p1_flag),
    .p1_valid(p1_valid), .p1_ready(p1_ready),
    .p0_out_valid(p0_out_valid), .p0_out_flag(p0_out_flag),
    .p1_out_valid(p1_out_valid), .p1_out_flag(p1_out_flag),
    .db_key(db_key), .db_flag(db_flag), .db_valid(db_valid),
    .db_out_valid(db_out_valid), .db_out_flag(db_out_flag),
    .outstanding(outstanding),
`ifdef DB_ARB_STATS_EN
    .p0_req_cnt(p0_req_cnt), .p1_req_cnt(p1_req_cnt),
    .drop_cnt(drop_cnt),
`endif
    .err_orphan(err_orphan)
  );

  typedef struct { logic [KW-1:0] key; logic [FW-1:0] flag; } req_t;
  typedef struct { int port; logic [FW-1:0] flag; } rsp_t;
  typedef struct { int port; logic [FW-1:0] flag; int cyc; } tag_t;
  typedef struct { bit chk; bit r0; bit r1; } rdy_t;
  typedef struct {
    int occ; bit err; bit dbv; bit s0; bit s1;
    logic [KW-1:0] key; logic [FW-1:0] flag;
    logic [FW-1:0] f0; logic [FW-1:0] f1;
    int c0; int c1; int drop;
  } st_t;

  req_t exp_req[$];
  rsp_t exp_rsp[$];
  st_t  exp_st[$];
  rdy_t exp_rdy[$];
  tag_t tq[$];

  int            lg;
  bit            m_err;
  logic [KW-1:0] m_key;
  logic [FW-1:0] m_flag;
  logic [FW-1:0] m_f[2];
  int            m_c[2];
  int            m_drop;
  int            cyc;

  bit            r_v[2];
  logic [KW-1:0] r_key[2];
  logic [FW-1:0] r_flag[2];
  int            left[2];
  int            pct[2];
  bit            seq;
  logic [KW-1:0] kseq;
  int            resp_pct, resp_dly;
  bit            echo, force_resp, do_rst;

  int checks, failures;
  bit mon_on;

  function automatic void chk(string nm, logic [127:0] act,
                              logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  task automatic step();
    int w; int occ_b; bit acc; bit resp;
    logic [FW-1:0] rflag;
    st_t e; rdy_t rd; req_t rq; rsp_t rs; tag_t h;
    bit have_rq, have_rs;
    for (int p = 0; p < 2; p++)
      if (!r_v[p] && left[p] > 0 &&
          int'($urandom_range(99)) < pct[p]) begin
        r_v[p] = 1'b1;
        left[p]--;
        if (seq) begin
          kseq = kseq + KW'(1);
          r_key[p] = kseq;
        end else begin
          r_key[p] = {$urandom, $urandom, $urandom};
        end
        r_flag[p] = FW'($urandom);
      end
    resp = force_resp ||
      (tq.size() > 0 && cyc >= tq[0].cyc + resp_dly &&
       int'($urandom_range(99)) < resp_pct);
    rflag = (echo && tq.size() > 0) ? tq[0].flag : FW'($urandom);
    rst = !do_rst;
    p0_valid = r_v[0]; p0_key = r_key[0]; p0_flag = r_flag[0];
    p1_valid = r_v[1]; p1_key = r_key[1]; p1_flag = r_flag[1];
    db_out_valid = resp;
    db_out_flag = rflag;
    occ_b = tq.size();
    w = -1;
    if (r_v[0] && r_v[1]) w = (lg == 0) ? 1 : 0;
    else if (r_v[0]) w = 0;
    else if (r_v[1]) w = 1;
    rd.chk = (w >= 0);
    rd.r0 = (w == 0) && occ_b < D;
    rd.r1 = (w == 1) && occ_b < D;
    exp_rdy.push_back(rd);
    acc = (w >= 0) && occ_b < D && !do_rst;
    have_rq = 1'b0; have_rs = 1'b0;
    e.s0 = 1'b0; e.s1 = 1'b0; e.dbv = 1'b0;
    if (do_rst) begin
      tq.delete();
      lg = 1; m_err = 1'b0; m_key = '0; m_flag = '0;
      m_f[0] = '0; m_f[1] = '0;
      m_c[0] = 0; m_c[1] = 0; m_drop = 0;
    end else begin
      if (resp) begin
        if (tq.size() > 0) begin
          h = tq.pop_front();
          rs.port = h.port; rs.flag = rflag; have_rs = 1'b1;
          m_f[h.port] = rflag;
          if (h.port == 0) e.s0 = 1'b1;
          else e.s1 = 1'b1;
        end else begin
          m_err = 1'b1;
          if (m_drop < 65535) m_drop++;
        end
      end
      if (acc) begin
        h.port = w; h.flag = r_flag[w]; h.cyc = cyc;
        tq.push_back(h);
        rq.key = r_key[w]; rq.flag = r_flag[w]; have_rq = 1'b1;
        m_key = r_key[w]; m_flag = r_flag[w];
        lg = w; m_c[w]++;
        e.dbv = 1'b1;
      end
    end
    e.occ = tq.size(); e.err = m_err;
    e.key = m_key; e.flag = m_flag;
    e.f0 = m_f[0]; e.f1 = m_f[1];
    e.c0 = m_c[0]; e.c1 = m_c[1]; e.drop = m_drop;
    @(posedge clk);
    cyc++;
    exp_st.push_back(e);
    if (have_rq) exp_req.push_back(rq);
    if (have_rs) exp_rsp.push_back(rs);
    #1;
    if (acc) r_v[w] = 1'b0;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  always @(negedge clk) begin
    rdy_t rd; st_t e; req_t rq; rsp_t rs;
    if (mon_on) begin
      if (exp_rdy.size() > 0) begin
        rd = exp_rdy.pop_front();
        if (rd.chk) begin
          chk("p0_ready", 128'(p0_ready), 128'(rd.r0));
          chk("p1_ready", 128'(p1_ready), 128'(rd.r1));
        end
      end
      if (exp_st.size() > 0) begin
        e = exp_st.pop_front();
        chk("outstanding", 128'(outstanding), 128'(e.occ));
        chk("err_orphan", 128'(err_orphan), 128'(e.err));
        chk("db_valid", 128'(db_valid), 128'(e.dbv));
        chk("p0_out_valid", 128'(p0_out_valid), 128'(e.s0));
        chk("p1_out_valid", 128'(p1_out_valid), 128'(e.s1));
        chk("db_key_hold", 128'(db_key), 128'(e.key));
        chk("db_flag_hold", 128'(db_flag), 128'(e.flag));
        chk("p0_out_flag", 128'(p0_out_flag), 128'(e.f0));
        chk("p1_out_flag", 128'(p1_out_flag), 128'(e.f1));
`ifdef DB_ARB_STATS_EN
        chk("p0_req_cnt", 128'(p0_req_cnt), 128'(e.c0));
        chk("p1_req_cnt", 128'(p1_req_cnt), 128'(e.c1));
        chk("drop_cnt", 128'(drop_cnt), 128'(e.drop));
`endif
      end
      if (db_valid === 1'b1) begin
        if (exp_req.size() > 0) begin
          rq = exp_req.pop_front();
          chk("req_key", 128'(db_key), 128'(rq.key));
          chk("req_flag", 128'(db_flag), 128'(rq.flag));
        end else begin
          checks++; failures++;
          $display("FAIL unexpected_db_valid: got 1 expected 0");
        end
      end
      if (p0_out_valid === 1'b1) begin
        if (exp_rsp.size() > 0) begin
          rs = exp_rsp.pop_front();
          chk("rsp_port_p0", 128'(0), 128'(rs.port));
          chk("rsp_flag_p0", 128'(p0_out_flag), 128'(rs.flag));
        end else begin
          checks++; failures++;
          $display("FAIL unexpected_p0_rsp: got 1 expected 0");
        end
      end
      if (p1_out_valid === 1'b1) begin
        if (exp_rsp.size() > 0) begin
          rs = exp_rsp.pop_front();
          chk("rsp_port_p1", 128'(1), 128'(rs.port));
          chk("rsp_flag_p1", 128'(p1_out_flag), 128'(rs.flag));
        end else begin
          checks++; failures++;
          $display("FAIL unexpected_p1_rsp: got 1 expected 0");
        end
      end
    end
  end

  initial begin
    checks = 0; failures = 0; mon_on = 1'b0; cyc = 0;
    lg = 1; m_err = 1'b0; m_drop = 0; kseq = '0; seq = 1'b1;
    m_key = '0; m_flag = '0; m_f[0] = '0; m_f[1] = '0;
    m_c[0] = 0; m_c[1] = 0;
    for (int p = 0; p < 2; p++) begin
      r_v[p] = 1'b0; r_key[p] = '0; r_flag[p] = '0;
      left[p] = 0; pct[p] = 0;
    end
    resp_pct = 0; resp_dly = 0;
    echo = 1'b0; force_resp = 1'b0; do_rst = 1'b1;
    rst = 1'b0; p0_valid = 1'b0; p1_valid = 1'b0;
    p0_key = '0; p1_key = '0; p0_flag = '0; p1_flag = '0;
    db_out_valid = 1'b0; db_out_flag = '0;
    @(posedge clk); #1;
    mon_on = 1'b1;
    run(1);
    do_rst = 1'b0;

    // single requester, db echoes flags 4 cycles later
    left[0] = 3; pct[0] = 100;
    resp_pct = 100; resp_dly = 4; echo = 1'b1;
    run(12);

    // continuous contention from a fresh reset
    do_rst = 1'b1; run(1); do_rst = 1'b0;
    left[0] = 4; left[1] = 4; pct[1] = 100; resp_dly = 2;
    run(16);

    // fill the tag FIFO, release one slot, then drain
    do_rst = 1'b1; run(1); do_rst = 1'b0;
    left[0] = 5; left[1] = 5; resp_pct = 0; echo = 1'b0;
    run(7);
    force_resp = 1'b1; run(1); force_resp = 1'b0;
    run(3);
    resp_pct = 100; resp_dly = 0;
    run(16);

    // push and pop together at occupancy 2
    do_rst = 1'b1; run(1); do_rst = 1'b0;
    left[0] = 2; left[1] = 0; resp_pct = 0;
    run(2);
    left[0] = 1; force_resp = 1'b1; run(1); force_resp = 1'b0;
    resp_pct = 100; run(6);

    // orphan response on an empty FIFO
    force_resp = 1'b1; run(1); force_resp = 1'b0;
    run(3);

    // reset with 3 outstanding, then orphan plus contention
    left[0] = 3; resp_pct = 0;
    run(4);
    left[0] = 1; left[1] = 1;
    do_rst = 1'b1; run(1); do_rst = 1'b0;
    force_resp = 1'b1; run(1); force_resp = 1'b0;
    resp_pct = 100; run(6);

    // randomized traffic
    seq = 1'b0;
    left[0] = 100000; left[1] = 100000;
    pct[0] = 55; pct[1] = 45; resp_pct = 40; resp_dly = 1;
    for (int i = 0; i < 3000; i++) begin
      do_rst = ($urandom_range(999) < 5);
      force_resp = (tq.size() == 0) && ($urandom_range(99) < 3);
      step();
    end
    do_rst = 1'b0; force_resp = 1'b0;
    left[0] = 0; left[1] = 0;
    resp_pct = 100; resp_dly = 0;
    run(30);

    @(negedge clk); #1;
    chk("req_queue_drained", 128'(exp_req.size()), 128'(0));
    chk("rsp_queue_drained", 128'(exp_rsp.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
